// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared constants and types for the sequential binary-to-BCD converter.
//   WIDTH_BIN : binary input width (14 bits covers 0..9999 plus overflow range)
//   WIDTH_SEG : width of one BCD digit
//   WIDTH_ACC : BCD accumulator width (four digits)
//   WIDTH_CNT : bit-counter width
//   BCD_MAX   : largest value that fits on four decimal digits
//   state_t   : converter FSM states
package bin2bcd_pkg;

  localparam int WIDTH_BIN = 14;
  localparam int WIDTH_SEG = 4;
  localparam int WIDTH_ACC = 4 * WIDTH_SEG;
  localparam int WIDTH_CNT = $clog2(WIDTH_BIN);

  localparam logic [WIDTH_BIN-1:0] BCD_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// bcd_adj3
// Combinational double-dabble digit correction: adds 3 to a BCD nibble
// when it is 5 or more, so the following left shift carries correctly
// into the next decimal digit.
//   din  : BCD nibble before correction
//   dout : corrected nibble (never exceeds 12 for valid BCD input)
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [WIDTH_SEG-1:0] din,
  output logic [WIDTH_SEG-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts a value on a valid/ready handshake, converts it in 14 CONV
// cycles, then loads four registered BCD digits in LOAD. Values above
// 9999 display as 9999 with o_ovf set.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_valid : i_bin is valid this cycle
//   i_bin   : unsigned binary value to convert
//   o_ready : converter idle, input accepted on i_valid && o_ready
//   o_done  : one-cycle pulse, digits were updated at the previous edge
//   o_ovf   : last accepted value exceeded 9999
//   o_dig1..o_dig4 : ones, tens, hundreds, thousands digits
module bin2bcd_seq #(
  parameter int WIDTH_BIN = bin2bcd_pkg::WIDTH_BIN,
  parameter int WIDTH_SEG = bin2bcd_pkg::WIDTH_SEG
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WIDTH_BIN-1:0] i_bin,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_ovf,
  output logic [WIDTH_SEG-1:0] o_dig1,
  output logic [WIDTH_SEG-1:0] o_dig2,
  output logic [WIDTH_SEG-1:0] o_dig3,
  output logic [WIDTH_SEG-1:0] o_dig4
);

  import bin2bcd_pkg::*;

  state_t state_reg, state_next;
  logic   accept;

  logic [WIDTH_BIN-1:0]           bin_reg;
  logic [WIDTH_ACC-1:0]           acc_reg;
  logic [WIDTH_ACC-1:0]           acc_adj;
  logic [WIDTH_CNT-1:0]           cnt_reg;
  logic                           ovf_q_reg;
  logic                           done_reg;
  logic                           ovf_reg;
  logic [3:0][WIDTH_SEG-1:0]      dig_reg;

  // The accumulator MSB after adjustment is shifted out and dropped; it is
  // always zero for in-range values and the overflow path ignores it.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_adj[WIDTH_ACC-1];

  // Per-digit add-3 correction, all four nibbles in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .din  (acc_reg[gi*WIDTH_SEG +: WIDTH_SEG]),
        .dout (acc_adj[gi*WIDTH_SEG +: WIDTH_SEG])
      );
    end
  endgenerate

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == '0) begin
          state_next = LOAD;
        end
      end
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;  // unused encoding recovers to idle
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_q_reg <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      dig_reg   <= '0;
    end else begin
      done_reg <= (state_reg == LOAD);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bin_reg   <= i_bin;
            acc_reg   <= '0;
            cnt_reg   <= WIDTH_CNT'(WIDTH_BIN - 1);
            ovf_q_reg <= (i_bin > BCD_MAX);
          end
        end
        CONV: begin
          // Shift {adjusted accumulator, binary} left by one.
          {acc_reg, bin_reg} <= {acc_adj[WIDTH_ACC-2:0], bin_reg, 1'b0};
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        LOAD: begin
          if (ovf_q_reg) begin
            dig_reg <= {4{4'd9}};
            ovf_reg <= 1'b1;
          end else begin
            dig_reg <= acc_reg;
            ovf_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state_reg == IDLE);
  assign o_done  = done_reg;
  assign o_ovf   = ovf_reg;
  assign o_dig1  = dig_reg[0];
  assign o_dig2  = dig_reg[1];
  assign o_dig3  = dig_reg[2];
  assign o_dig4  = dig_reg[3];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Expected digits come from a decimal
// model (division/modulo), independent of the shift-and-add-3 datapath.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [13:0] bin;
  logic        ready;
  logic        done;
  logic        ovf;
  logic [3:0]  dig1, dig2, dig3, dig4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_bin   (bin),
    .o_ready (ready),
    .o_done  (done),
    .o_ovf   (ovf),
    .o_dig1  (dig1),
    .o_dig2  (dig2),
    .o_dig3  (dig3),
    .o_dig4  (dig4)
  );

  function automatic logic [15:0] ref_digits(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic ref_ovf(input int v);
    return v > 9999;
  endfunction

  function automatic logic [15:0] obs_digits();
    return {dig4, dig3, dig2, dig1};
  endfunction

  // Drives one accept and waits (bounded) for o_done. Returns the number of
  // clocks from the accept edge to the o_done cycle, or -1 on timeout.
  // Leaves the bench at the negedge of the o_done cycle.
  task automatic run_conv(input logic [13:0] v, output int lat);
    @(negedge clk);
    valid = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    bin   = 14'($urandom_range(0, 16383));  // must not affect the conversion
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    $display("conv in=%0d lat=%0d digits=%h ovf=%b", v, lat, obs_digits(), ovf);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (obs_digits() !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", obs_digits()); end
    $display("reset ready=%b done=%b digits=%h", ready, done, obs_digits());
  endtask

  task automatic test_basic();
    int lat;
    run_conv(14'd1234, lat);
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL basic_latency got %0d want 15", lat); end
    checks++;
    if (obs_digits() !== 16'h1234) begin errors++; $display("FAIL basic_digits got %h want 1234", obs_digits()); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++;
    if (obs_digits() !== 16'h1234) begin errors++; $display("FAIL basic_hold got %h want 1234", obs_digits()); end
  endtask

  task automatic test_values(input string name, input int v);
    int lat;
    run_conv(14'(v), lat);
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL %s_latency in=%0d got %0d want 15", name, v, lat); end
    checks++;
    if (obs_digits() !== ref_digits(v)) begin
      errors++; $display("FAIL %s_digits in=%0d got %h want %h", name, v, obs_digits(), ref_digits(v));
    end
    checks++;
    if (ovf !== ref_ovf(v)) begin errors++; $display("FAIL %s_ovf in=%0d got %b want %b", name, v, ovf, ref_ovf(v)); end
  endtask

  task automatic test_edges();
    test_values("edge", 0);
    test_values("edge", 9999);
  endtask

  task automatic test_overflow();
    test_values("ovf", 10000);
    test_values("ovf", 16383);
    test_values("ovf", 42);
  endtask

  task automatic test_ignore_valid();
    int n_done = 0;
    logic [15:0] first = '0;
    @(negedge clk);
    valid = 1'b1;
    bin   = 14'd5678;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    valid = 1'b1;
    bin   = 14'd7777;
    @(negedge clk);
    valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        if (n_done == 0) first = obs_digits();
        n_done++;
      end
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
    checks++;
    if (first !== 16'h5678) begin errors++; $display("FAIL ignore_digits got %h want 5678", first); end
    checks++;
    if (obs_digits() !== 16'h5678) begin errors++; $display("FAIL ignore_final got %h want 5678", obs_digits()); end
    $display("ignore dones=%0d digits=%h", n_done, obs_digits());
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    @(negedge clk);
    valid = 1'b1;
    bin   = 14'd4321;
    @(posedge clk);            // E0
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(posedge clk); // E1..E6
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);            // E7
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready); end
    checks++;
    if (obs_digits() !== 16'h0000) begin errors++; $display("FAIL midrst_digits got %h want 0000", obs_digits()); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", ovf); end
    for (int n = 0; n < 25; n++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", n_done); end
    $display("midrst dones=%0d digits=%h", n_done, obs_digits());
    test_values("midrst_again", 4321);
  endtask

  task automatic test_back_to_back();
    int          q[$];
    int          last_acc = -1;
    int          n_done = 0;
    int          v;
    logic [15:0] held;
    held = obs_digits();
    for (int cyc = 0; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_done cyc=%0d got %h want none", cyc, obs_digits());
        end else begin
          v = q.pop_front();
          if (obs_digits() !== ref_digits(v) || ovf !== ref_ovf(v)) begin
            errors++;
            $display("FAIL b2b_result in=%0d got %h/%b want %h/%b", v, obs_digits(), ovf, ref_digits(v), ref_ovf(v));
          end
          $display("b2b in=%0d digits=%h ovf=%b", v, obs_digits(), ovf);
        end
        held = obs_digits();
      end else begin
        checks++;
        if (obs_digits() !== held) begin
          errors++; $display("FAIL b2b_hold cyc=%0d got %h want %h", cyc, obs_digits(), held);
        end
      end
      valid = (cyc < 80);
      bin   = 14'($urandom_range(0, 16383));
      if (valid && ready) begin
        q.push_back(int'(bin));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 16) begin
            errors++; $display("FAIL b2b_interval got %0d want 16", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
    end
    valid = 1'b0;
    checks++;
    if (n_done !== 5) begin errors++; $display("FAIL b2b_done_count got %0d want 5", n_done); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL b2b_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_values("rand", int'($urandom_range(0, 16383)));
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    bin   = '0;
    test_reset();
    test_basic();
    test_edges();
    test_overflow();
    test_ignore_valid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
